// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I/RV32E core (lw, sw, ALU R/I, beq, bne, jal) with one shared
// ready/valid memory port; datapath and main-decoder FSM live in this one module.
module rv_multicycle_core #(
  parameter int          NREGS        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  localparam int RW = $clog2(NREGS);
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, oldpc_q, oldpc_d;
  logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, data_q, data_d;
  logic [31:0] rf_q [NREGS];

  logic [6:0]    opcode_s, f7_s;
  logic [4:0]    rd_s, rs1_s, rs2_s;
  logic [2:0]    f3_s;
  logic [RW-1:0] rd_idx_s, rs1_idx_s, rs2_idx_s;
  logic [31:0]   imm_i_s, imm_s_s, imm_b_s, imm_j_s, rs1_val_s, rs2_val_s, madr_s;
  logic          legal_s, use_rs1_s, use_rs2_s, use_rd_s, reg_bad_s;
  state_e        dispatch_s;
  logic          rf_we_s, mem_req_s, mem_we_s, retire_s, halted_s;
  logic [31:0]   rf_wdata_s, mem_addr_s;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu = sub ? (a - b) : (a + b);
      3'b111:  alu = a & b;
      3'b110:  alu = a | b;
      3'b010:  alu = {31'd0, ($signed(a) < $signed(b))};
      default: alu = a + b;
    endcase
  endfunction

  assign opcode_s  = ir_q[6:0];
  assign rd_s      = ir_q[11:7];
  assign f3_s      = ir_q[14:12];
  assign rs1_s     = ir_q[19:15];
  assign rs2_s     = ir_q[24:20];
  assign f7_s      = ir_q[31:25];
  assign rd_idx_s  = rd_s[RW-1:0];
  assign rs1_idx_s = rs1_s[RW-1:0];
  assign rs2_idx_s = rs2_s[RW-1:0];
  assign imm_i_s   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b_s   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j_s   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val_s = (rs1_idx_s == '0) ? 32'd0 : rf_q[rs1_idx_s];
  assign rs2_val_s = (rs2_idx_s == '0) ? 32'd0 : rf_q[rs2_idx_s];
  assign madr_s    = a_q + ((opcode_s == OP_SW) ? imm_s_s : imm_i_s);

  // Instruction legality and dispatch target; register fields are only checked where the format has them.
  always_comb begin
    legal_s    = 1'b0;
    use_rs1_s  = 1'b0;
    use_rs2_s  = 1'b0;
    use_rd_s   = 1'b0;
    dispatch_s = S_HALT;
    case (opcode_s)
      OP_LW:  begin legal_s = (f3_s == 3'b010); use_rs1_s = 1'b1; use_rd_s = 1'b1; dispatch_s = S_MEMADR; end
      OP_SW:  begin legal_s = (f3_s == 3'b010); use_rs1_s = 1'b1; use_rs2_s = 1'b1; dispatch_s = S_MEMADR; end
      OP_R: begin
        legal_s = ((f7_s == 7'h00) && ((f3_s == 3'b000) || (f3_s == 3'b111) ||
                                       (f3_s == 3'b110) || (f3_s == 3'b010))) ||
                  ((f7_s == 7'h20) && (f3_s == 3'b000));
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b1; dispatch_s = S_EXECR;
      end
      OP_I: begin
        legal_s = (f3_s == 3'b000) || (f3_s == 3'b111) || (f3_s == 3'b110) || (f3_s == 3'b010);
        use_rs1_s = 1'b1; use_rd_s = 1'b1; dispatch_s = S_EXECI;
      end
      OP_BR:  begin legal_s = (f3_s == 3'b000) || (f3_s == 3'b001); use_rs1_s = 1'b1; use_rs2_s = 1'b1; dispatch_s = S_BRANCH; end
      OP_JAL: begin legal_s = 1'b1; use_rd_s = 1'b1; dispatch_s = S_JAL; end
      default: begin legal_s = 1'b0; dispatch_s = S_HALT; end
    endcase
    reg_bad_s = (use_rs1_s && ({1'b0, rs1_s} >= NREGS_L)) ||
                (use_rs2_s && ({1'b0, rs2_s} >= NREGS_L)) ||
                (use_rd_s  && ({1'b0, rd_s}  >= NREGS_L));
  end

  // Main decoder FSM: next state, datapath register updates and port outputs.
  always_comb begin
    state_d = state_q;  pc_d = pc_q;  ir_d = ir_q;  oldpc_d = oldpc_q;
    a_d = a_q;  b_d = b_q;  aluout_d = aluout_q;  data_d = data_q;
    rf_we_s = 1'b0;  rf_wdata_s = 32'd0;
    mem_req_s = 1'b0;  mem_we_s = 1'b0;  mem_addr_s = aluout_q;
    retire_s = 1'b0;  halted_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_addr_s = {pc_q[31:2], 2'b00};
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_HALT;
        end else begin
          mem_req_s = 1'b1;
          if (mem_ready) begin
            ir_d = mem_rdata;  oldpc_d = pc_q;  pc_d = pc_q + 32'd4;  state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DECODE: begin
        a_d      = rs1_val_s;
        b_d      = rs2_val_s;
        aluout_d = oldpc_q + ((opcode_s == OP_JAL) ? imm_j_s : imm_b_s);
        state_d  = (legal_s && !reg_bad_s) ? dispatch_s : S_HALT;
      end
      S_MEMADR: begin
        aluout_d = madr_s;
        if (madr_s[1:0] != 2'b00) state_d = S_HALT;
        else                      state_d = (opcode_s == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin data_d = mem_rdata; state_d = S_MEMWB; end
        else           begin state_d = S_MEMREAD; end
      end
      S_MEMWB:  begin rf_we_s = 1'b1; rf_wdata_s = data_q; retire_s = 1'b1; state_d = S_FETCH; end
      S_MEMWRITE: begin
        mem_req_s = 1'b1;  mem_we_s = 1'b1;
        if (mem_ready) begin retire_s = 1'b1; state_d = S_FETCH; end
        else           begin state_d = S_MEMWRITE; end
      end
      S_EXECR:  begin aluout_d = alu(f3_s, f7_s[5], a_q, b_q);  state_d = S_ALUWB; end
      S_EXECI:  begin aluout_d = alu(f3_s, 1'b0, a_q, imm_i_s); state_d = S_ALUWB; end
      S_ALUWB:  begin rf_we_s = 1'b1; rf_wdata_s = aluout_q; retire_s = 1'b1; state_d = S_FETCH; end
      S_BRANCH: begin
        // funct3[0] distinguishes bne from beq
        if ((a_q == b_q) ^ f3_s[0]) pc_d = aluout_q;
        else                        pc_d = pc_q;
        retire_s = 1'b1;  state_d = S_FETCH;
      end
      S_JAL: begin
        rf_we_s = 1'b1;  rf_wdata_s = oldpc_q + 32'd4;  pc_d = aluout_q;
        retire_s = 1'b1;  state_d = S_FETCH;
      end
      S_HALT:  begin halted_s = 1'b1; state_d = S_HALT; end
      default: begin state_d = S_HALT; end
    endcase
  end

  // Datapath and state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;  pc_q <= RESET_VECTOR;  ir_q <= 32'd0;  oldpc_q <= 32'd0;
      a_q <= 32'd0;  b_q <= 32'd0;  aluout_q <= 32'd0;  data_q <= 32'd0;
    end else begin
      state_q <= state_d;  pc_q <= pc_d;  ir_q <= ir_d;  oldpc_q <= oldpc_d;
      a_q <= a_d;  b_q <= b_d;  aluout_q <= aluout_d;  data_q <= data_d;
    end
  end

  // Register file; x0 is never written.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'd0;
    end else if (rf_we_s && (rd_idx_s != '0)) begin
      rf_q[rd_idx_s] <= rf_wdata_s;
    end
  end

  assign mem_req   = mem_req_s & ~RESET;
  assign mem_we    = mem_we_s & ~RESET;
  assign retire    = retire_s & ~RESET;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign halted    = halted_s;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core: a wait-state memory model, write log,
// retire-interval log and hand-computed expectations for each program.
module tb_rv_multicycle_core;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        req16, we16, ready16, retire16, halted16;
  logic [31:0] addr16, wdata16, rdata16, pc16;

  logic [31:0] mem [0:1023];
  int          n_checks = 0, n_fail = 0;
  int          wait_max = 0, wait_cnt = 0, req_cnt = 0, req16_cnt = 0, cyc = 0, last_ret = 0;
  logic        stall_wr = 1'b0, in_rst = 1'b1;
  logic        p_req = 1'b0, p_rdy = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
  logic [31:0] wa_q[$], wd_q[$];
  int          cpi_q[$];

  always #5 CLK = ~CLK;

  rv_multicycle_core #(.NREGS(32), .RESET_VECTOR(32'h100)) u_dut (
    .CLK(CLK), .RESET(RESET), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc),
    .retire(retire), .halted(halted));

  rv_multicycle_core #(.NREGS(16), .RESET_VECTOR(32'h0)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_ready(ready16), .mem_rdata(rdata16), .pc(pc16),
    .retire(retire16), .halted(halted16));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3, input int rd, input logic [6:0] op);
    logic [11:0] i12 = 12'(imm);
    return {i12, 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1, input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] s12 = 12'(imm);
    return {s12[11:5], 5'(rs2), 5'(rs1), 3'b010, s12[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] b13 = 13'(imm);
    return {b13[12], b13[10:5], 5'(rs2), 5'(rs1), f3, b13[4:1], b13[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] j21 = 21'(imm);
    return {j21[20], j21[10:1], j21[11], j21[19:12], 5'(rd), 7'h6F};
  endfunction

  // Memory model: random wait states, write log, request-stability check
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge CLK); #1;
      if (p_req && p_rdy) begin
        if (p_we) begin
          mem[p_addr[11:2]] = p_wdata;
          wa_q.push_back(p_addr);
          wd_q.push_back(p_wdata);
        end
        wait_cnt = (wait_max == 0) ? 0 : int'($urandom_range(wait_max, 0));
      end
      if (mem_req) begin
        req_cnt++;
        if (p_req && !p_rdy) begin
          check_eq("hold_addr", mem_addr, p_addr);
          check_eq("hold_we", {31'd0, mem_we}, {31'd0, p_we});
          check_eq("hold_wdata", mem_wdata, p_wdata);
        end
        if (stall_wr && mem_we) begin
          mem_ready = 1'b0;
        end else if (wait_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[11:2]];
        end else begin
          mem_ready = 1'b0;
          wait_cnt--;
        end
      end else begin
        mem_ready = 1'b0;
      end
      p_req = mem_req; p_rdy = mem_ready; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
    end
  end

  // RV32E instance always sees addi x20,x0,1 with zero wait
  initial begin
    ready16 = 1'b1;
    rdata16 = enc_i(1, 0, 3'b000, 20, 7'h13);
    forever begin
      @(negedge CLK); #1;
      if (req16) begin
        req16_cnt++;
        check_eq("d16_fetch_addr", addr16, 32'h0);
      end
    end
  end

  // Retire monitor: cycles taken by each instruction
  initial begin
    forever begin
      @(negedge CLK); #2;
      cyc++;
      if (RESET) begin
        in_rst = 1'b1;
      end else begin
        if (in_rst) last_ret = cyc - 1;
        in_rst = 1'b0;
        if (retire) begin
          cpi_q.push_back(cyc - last_ret);
          last_ret = cyc;
        end
      end
    end
  end

  task automatic put(input int addr, input logic [31:0] w);
    mem[addr >> 2] = w;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); @(negedge CLK); #3;
    if (chk) begin
      check_eq("rst_pc", pc, 32'h100);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      check_eq("rst_retire", {31'd0, retire}, 32'd0);
      check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    end
    wa_q.delete(); wd_q.delete(); cpi_q.delete();
    req_cnt = 0; req16_cnt = 0; wait_cnt = 0;
    @(negedge CLK); RESET = 1'b0;
    #3;
    if (chk) begin
      check_eq("first_req", {31'd0, mem_req}, 32'd1);
      check_eq("first_addr", mem_addr, 32'h100);
      check_eq("first_we", {31'd0, mem_we}, 32'd0);
    end
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 2000) begin
      @(negedge CLK); n++;
    end
    #3;
    check_eq("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic load_prog_a();
    put(32'h100, enc_i(5, 0, 3'b000, 1, 7'h13));        // addi x1,x0,5
    put(32'h104, enc_i(-3, 0, 3'b000, 2, 7'h13));       // addi x2,x0,-3
    put(32'h108, enc_r(7'h00, 2, 1, 3'b000, 3));        // add  x3,x1,x2
    put(32'h10C, enc_r(7'h00, 1, 2, 3'b010, 4));        // slt  x4,x2,x1
    put(32'h110, enc_r(7'h20, 2, 1, 3'b000, 7));        // sub  x7,x1,x2
    put(32'h114, enc_r(7'h00, 2, 1, 3'b111, 8));        // and  x8,x1,x2
    put(32'h118, enc_r(7'h00, 2, 1, 3'b110, 9));        // or   x9,x1,x2
    put(32'h11C, enc_i(15, 2, 3'b111, 10, 7'h13));      // andi x10,x2,15
    put(32'h120, enc_i(48, 1, 3'b110, 11, 7'h13));      // ori  x11,x1,0x30
    put(32'h124, enc_i(0, 2, 3'b010, 12, 7'h13));       // slti x12,x2,0
    put(32'h128, enc_s(8, 3, 0));                       // sw x3,8(x0)
    put(32'h12C, enc_i(8, 0, 3'b010, 5, 7'h03));        // lw x5,8(x0)
    put(32'h130, enc_s(12, 5, 0));
    put(32'h134, enc_s(16, 4, 0));
    put(32'h138, enc_s(20, 7, 0));
    put(32'h13C, enc_s(24, 8, 0));
    put(32'h140, enc_s(28, 9, 0));
    put(32'h144, enc_s(32, 10, 0));
    put(32'h148, enc_s(36, 11, 0));
    put(32'h14C, enc_s(40, 12, 0));
    put(32'h150, enc_i(9, 0, 3'b000, 0, 7'h13));        // addi x0,x0,9
    put(32'h154, enc_s(48, 0, 0));                      // sw x0,48(x0)
    put(32'h158, enc_b(8, 2, 1, 3'b000));               // beq x1,x2,+8 (not taken)
    put(32'h15C, enc_b(12, 0, 1, 3'b001));              // bne x1,x0,+12 (taken)
    put(32'h160, enc_s(44, 6, 0));                      // sw x6,44(x0)
    put(32'h164, 32'h0000_0073);                        // illegal
    put(32'h168, enc_j(-8, 6));                         // jal x6,-8
  endtask

  task automatic check_writes_a(input string tag);
    logic [31:0] exp_wa [11] = '{32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28,
                                 32'd32, 32'd36, 32'd40, 32'd48, 32'd44};
    logic [31:0] exp_wd [11] = '{32'd2, 32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD,
                                 32'hD, 32'h35, 32'd1, 32'd0, 32'h16C};
    check_eq({tag, "_nwrites"}, 32'(wa_q.size()), 32'd11);
    for (int i = 0; i < 11 && i < wa_q.size(); i++) begin
      check_eq($sformatf("%s_wa%0d", tag, i), wa_q[i], exp_wa[i]);
      check_eq($sformatf("%s_wd%0d", tag, i), wd_q[i], exp_wd[i]);
    end
    check_eq({tag, "_pc"}, pc, 32'h168);
  endtask

  initial begin
    int exp_cpi [26] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, 4,
                         4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 3, 3, 4};
    int n;
    int rc;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    // Program A, zero wait: results and cycles per instruction
    load_prog_a();
    do_reset(1'b1);
    wait_halt();
    repeat (3) @(negedge CLK);
    check_writes_a("zw");
    check_eq("zw_nretire", 32'(cpi_q.size()), 32'd26);
    for (int i = 0; i < 26 && i < cpi_q.size(); i++)
      check_eq($sformatf("cpi%0d", i), 32'(cpi_q[i]), 32'(exp_cpi[i]));
    rc = req_cnt;
    repeat (10) @(negedge CLK);
    #3;
    check_eq("halt_no_req", 32'(req_cnt), 32'(rc));
    check_eq("halt_pc_frozen", pc, 32'h168);

    // Program A again with 0-3 random wait states
    wait_max = 3;
    do_reset(1'b0);
    wait_halt();
    repeat (3) @(negedge CLK);
    check_writes_a("rw");
    wait_max = 0;

    // Misaligned load halts without a data request; RV32E instance rejects x20
    put(32'h100, enc_i(1, 0, 3'b010, 1, 7'h03));        // lw x1,1(x0)
    put(32'h104, enc_s(0, 0, 0));
    do_reset(1'b0);
    wait_halt();
    repeat (5) @(negedge CLK);
    #3;
    check_eq("mis_lw_reqs", 32'(req_cnt), 32'd1);
    check_eq("mis_lw_pc", pc, 32'h104);
    check_eq("mis_lw_writes", 32'(wa_q.size()), 32'd0);
    check_eq("d16_halted", {31'd0, halted16}, 32'd1);
    check_eq("d16_reqs", 32'(req16_cnt), 32'd1);
    check_eq("d16_pc", pc16, 32'h4);
    check_eq("d16_retire", {31'd0, retire16}, 32'd0);
    check_eq("d16_we", {31'd0, we16}, 32'd0);
    check_eq("d16_wdata", wdata16, 32'd0);

    // Misaligned jump target halts at the next fetch
    put(32'h100, enc_j(6, 0));                          // jal x0,+6
    do_reset(1'b0);
    wait_halt();
    check_eq("mis_pc_reqs", 32'(req_cnt), 32'd1);
    check_eq("mis_pc_pc", pc, 32'h106);
    check_eq("mis_pc_nretire", 32'(cpi_q.size()), 32'd1);

    // Reset during a stalled store: no write, registers cleared
    put(32'h100, enc_i(7, 0, 3'b000, 1, 7'h13));        // addi x1,x0,7
    put(32'h104, enc_s(52, 1, 0));                      // sw x1,52(x0)
    stall_wr = 1'b1;
    do_reset(1'b0);
    n = 0;
    while (!(mem_req && mem_we) && n < 100) begin
      @(negedge CLK); #3; n++;
    end
    check_eq("stall_store_seen", {31'd0, mem_req & mem_we}, 32'd1);
    check_eq("stall_store_data", mem_wdata, 32'd7);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #3;
    check_eq("rst_drops_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_drops_we", {31'd0, mem_we}, 32'd0);
    put(32'h100, enc_s(52, 1, 0));                      // sw x1,52(x0)
    put(32'h104, 32'h0000_0073);
    stall_wr = 1'b0;
    @(negedge CLK); @(negedge CLK);
    wa_q.delete(); wd_q.delete(); wait_cnt = 0;
    @(negedge CLK); RESET = 1'b0;
    #3;
    check_eq("restart_req", {31'd0, mem_req}, 32'd1);
    check_eq("restart_addr", mem_addr, 32'h100);
    wait_halt();
    check_eq("restart_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() > 0) begin
      check_eq("restart_wa", wa_q[0], 32'd52);
      check_eq("restart_wd", wd_q[0], 32'd0);
    end
    check_eq("restart_mem52", mem[13], 32'd0);
    check_eq("restart_pc", pc, 32'h108);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
